fetch_unit: RTL

Program counter, instruction-memory fetch engine and instruction register for the accumulator CPU. Sits directly upstream of the controller. It executes the controller's LoadIR/IncPC/LoadPC/SelPC commands, fetches 16-bit instruction words over a request/acknowledge memory port, and presents the captured opcode and immediate back to the controller and datapath. It also detects HALT, and flags fetch timeouts so a missing memory response cannot hang the CPU.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out of the fetch unit,
// acknowledge/data back from memory.
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter, instruction fetch engine and instruction register for the
// accumulator CPU; detects HALT and aborts fetches that never get acknowledged.
module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            LoadIR,
    input  logic            IncPC,
    input  logic            LoadPC,
    input  logic            SelPC,
    input  logic [PC_W-1:0] reg_target,
    fetch_unit_if.master    mem,
    output logic [7:0]      Opcode,
    output logic [7:0]      Immediate,
    output logic [PC_W-1:0] PC,
    output logic            ir_valid,
    output logic            busy,
    output logic            fetch_err,
    output logic            halted
);
    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]      OP_HALT  = 8'h0F;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] imm_target;
    logic [15:0]     ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic            req_q;
    logic [PC_W-1:0] addr_q;
    logic            valid_q;
    logic            err_q;
    logic            halted_q;

    // Size cast zero-extends or truncates the 8-bit immediate to the PC width.
    assign imm_target = PC_W'(ir_q[7:0]);

    always_comb begin
        pc_d = pc_q;
        if (!halted_q) begin
            if (LoadPC)
                pc_d = SelPC ? imm_target : reg_target;
            else if (IncPC)
                pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE: begin
                    // Address is latched from the pre-update PC so a same-edge IncPC
                    // does not move the fetch.
                    if (LoadIR && !halted_q) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    // Acknowledge is checked first so it wins over a coincident timeout.
                    if (mem.imem_ack) begin
                        state_q <= IDLE;
                        ir_q    <= mem.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        if (mem.imem_rdata[15:8] == OP_HALT)
                            halted_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        ir_q    <= '0;
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.imem_req  = req_q;
    assign mem.imem_addr = addr_q;
    assign Opcode        = ir_q[15:8];
    assign Immediate     = ir_q[7:0];
    assign PC            = pc_q;
    assign ir_valid      = valid_q;
    assign busy          = (state_q == WAIT);
    assign fetch_err     = err_q;
    assign halted        = halted_q;
endmodule
